// File: rtl/video_pattern_pkg.sv
// Shared definitions for the colour-bar video source: bar ordering, per-bar RGB on/off flags
// and a helper that expands those flags into full-scale packed {R,G,B} components.
package video_pattern_pkg;

   localparam int NUM_BARS  = 8;
   localparam int MAX_PX_W  = 32;
   localparam int MAX_RGB_W = 3 * MAX_PX_W;

   typedef enum logic [2:0] {
      BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
      BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
   } bar_e;

   // Flags are {R,G,B}; a set flag means that component is at full scale.
   localparam logic [2:0] BAR_RGB_FLAGS [NUM_BARS] = '{
      3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
   };

   function automatic logic [MAX_RGB_W-1:0] pack_rgb(input logic [2:0] flags, input int px_w);
      logic [MAX_RGB_W-1:0] v;
      v = '0;
      for (int c = 0; c < 3; c++) begin
         for (int b = 0; b < MAX_PX_W; b++) begin
            if (b < px_w && flags[c]) v[c*px_w + b] = 1'b1;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle carrying video beats (TUSER = start of frame, TLAST = end of line).
interface axi4_stream_if #(
   parameter int TDATA_WIDTH = 32
) ();
   logic                     tvalid;
   logic                     tready;
   logic [TDATA_WIDTH-1:0]   tdata;
   logic [TDATA_WIDTH/8-1:0] tstrb;
   logic [TDATA_WIDTH/8-1:0] tkeep;
   logic                     tuser;
   logic                     tlast;
   logic                     tid;
   logic                     tdest;

   modport master (
      output tvalid, tdata, tstrb, tkeep, tuser, tlast, tid, tdest,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tkeep, tuser, tlast, tid, tdest,
      output tready
   );
endinterface

// File: rtl/video_bar_color_lut.sv
// Combinational lookup from bar index (0..7) to the packed {R,G,B} colour of that bar.
module video_bar_color_lut
   import video_pattern_pkg::*;
#(
   parameter int PX_WIDTH = 10
) (
   input  logic [2:0]            i_bar,
   output logic [3*PX_WIDTH-1:0] o_rgb
);

   bar_e w_bar;

   assign w_bar = bar_e'(i_bar);
   assign o_rgb = (3*PX_WIDTH)'(pack_rgb(BAR_RGB_FLAGS[w_bar], PX_WIDTH));

endmodule

// File: rtl/axi4_video_test_pattern_gen.sv
// Free-running 8-bar colour pattern source with raster pacing (active pixels then blanking slots).
// Define PATTERN_GEN_MOVING_BARS_EN to scroll the bars left by one pixel per frame.
module axi4_video_test_pattern_gen
   import video_pattern_pkg::*;
#(
   parameter int Y_ACTIVE    = 1080,
   parameter int Y_BLANKING  = 45,
   parameter int X_ACTIVE    = 1920,
   parameter int X_BLANKING  = 280,
   parameter int PX_WIDTH    = 10,
   parameter int TDATA_WIDTH = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   axi4_stream_if.master video_o
);

   localparam int X_TOTAL = X_ACTIVE + X_BLANKING;
   localparam int Y_TOTAL = Y_ACTIVE + Y_BLANKING;
   localparam int XW      = $clog2(X_TOTAL + 1);
   localparam int YW      = $clog2(Y_TOTAL + 1);
   localparam int BAR_W   = (X_ACTIVE / NUM_BARS < 1) ? 1 : X_ACTIVE / NUM_BARS;
   localparam int RGB_W   = 3 * PX_WIDTH;

   localparam logic [XW-1:0] X_ACT_C    = XW'(X_ACTIVE);
   localparam logic [XW-1:0] X_LAST_ACT = XW'(X_ACTIVE - 1);
   localparam logic [XW-1:0] X_LAST     = XW'(X_TOTAL - 1);
   localparam logic [YW-1:0] Y_ACT_C    = YW'(Y_ACTIVE);
   localparam logic [YW-1:0] Y_LAST     = YW'(Y_TOTAL - 1);

   logic [XW-1:0]    r_x_cnt;
   logic [YW-1:0]    r_y_cnt;
   logic             w_active;
   logic             w_advance;
   logic             w_line_wrap;
   logic             w_frame_wrap;
   logic [XW-1:0]    w_x_pos;
   logic [31:0]      w_bar_idx;
   logic [2:0]       w_bar;
   logic [RGB_W-1:0] w_rgb;

   // Outputs are gated by reset so the stream goes quiet the instant reset is asserted.
   assign w_active     = !rst_i && (r_x_cnt < X_ACT_C) && (r_y_cnt < Y_ACT_C);
   assign w_advance    = !w_active || video_o.tready;
   assign w_line_wrap  = (r_x_cnt == X_LAST);
   assign w_frame_wrap = w_line_wrap && (r_y_cnt == Y_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_x_cnt <= '0;
         r_y_cnt <= '0;
      end else if (w_advance) begin
         if (w_line_wrap) begin
            r_x_cnt <= '0;
            r_y_cnt <= w_frame_wrap ? '0 : r_y_cnt + 1'b1;
         end else begin
            r_x_cnt <= r_x_cnt + 1'b1;
         end
      end
   end

`ifdef PATTERN_GEN_MOVING_BARS_EN
   logic [XW-1:0] r_x_off;
   logic [XW:0]   w_x_sum;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_x_off <= '0;
      end else if (w_advance && w_frame_wrap) begin
         r_x_off <= (r_x_off == X_LAST_ACT) ? '0 : r_x_off + 1'b1;
      end
   end

   // Both terms are below X_ACTIVE in the active region, so one conditional subtract is a full modulo.
   assign w_x_sum = {1'b0, r_x_cnt} + {1'b0, r_x_off};
   assign w_x_pos = (w_x_sum >= {1'b0, X_ACT_C}) ? XW'(w_x_sum - {1'b0, X_ACT_C}) : XW'(w_x_sum);
`else
   assign w_x_pos = r_x_cnt;
`endif

   assign w_bar_idx = 32'(w_x_pos) / 32'(BAR_W);
   assign w_bar     = (w_bar_idx > 32'd7) ? 3'd7 : w_bar_idx[2:0];

   video_bar_color_lut #(
      .PX_WIDTH (PX_WIDTH)
   ) u_lut (
      .i_bar (w_bar),
      .o_rgb (w_rgb)
   );

   assign video_o.tvalid = w_active;
   assign video_o.tdata  = w_active ? TDATA_WIDTH'(w_rgb) : '0;
   assign video_o.tuser  = w_active && (r_x_cnt == '0) && (r_y_cnt == '0);
   assign video_o.tlast  = w_active && (r_x_cnt == X_LAST_ACT);
   assign video_o.tstrb  = '1;
   assign video_o.tkeep  = '1;
   assign video_o.tid    = 1'b0;
   assign video_o.tdest  = 1'b0;

endmodule

// File: tb/tb_axi4_video_test_pattern_gen.sv
// Directed bench for the colour-bar source on a 16x4 active / 20x6 total raster.
module tb_axi4_video_test_pattern_gen;

   localparam int XA = 16, XB = 4, YA = 4, YB = 2;
   localparam int XT = XA + XB, YT = YA + YB, FRAME = XT * YT, BEATS = XA * YA;
`ifdef PATTERN_GEN_MOVING_BARS_EN
   localparam int MOVE = 1;
`else
   localparam int MOVE = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   axi4_stream_if #(.TDATA_WIDTH(32)) vif ();

   axi4_video_test_pattern_gen #(
      .Y_ACTIVE (YA), .Y_BLANKING (YB), .X_ACTIVE (XA), .X_BLANKING (XB),
      .PX_WIDTH (10), .TDATA_WIDTH (32)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .video_o (vif)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bar_color(input int bar);
      case (bar)
         0: return 32'h3FFF_FFFF;
         1: return 32'h3FFF_FC00;
         2: return 32'h000F_FFFF;
         3: return 32'h000F_FC00;
         4: return 32'h3FF0_03FF;
         5: return 32'h3FF0_0000;
         6: return 32'h0000_03FF;
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] exp_pix(input int x, input int f);
      int xp;
      xp = (x + MOVE * (f % XA)) % XA;
      return bar_color(xp / 2);
   endfunction

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      vif.tready = 1'b1;
      @(negedge clk);
      checks++; if (vif.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", vif.tvalid); end
      checks++; if (vif.tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b want 0", vif.tuser); end
      checks++; if (vif.tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h want 0", vif.tdata); end
      checks++; if (vif.tkeep !== 4'hF || vif.tstrb !== 4'hF) begin errors++; $display("FAIL rst_keep_strb: got %h/%h want F/F", vif.tkeep, vif.tstrb); end
      checks++; if (vif.tid !== 1'b0 || vif.tdest !== 1'b0) begin errors++; $display("FAIL rst_id_dest: got %b/%b want 0/0", vif.tid, vif.tdest); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (vif.tvalid !== 1'b1) begin errors++; $display("FAIL first_tvalid: got %b want 1", vif.tvalid); end
      checks++; if (vif.tuser !== 1'b1) begin errors++; $display("FAIL first_tuser: got %b want 1", vif.tuser); end
      checks++; if (vif.tdata !== 32'h3FFF_FFFF) begin errors++; $display("FAIL first_tdata: got %h want 3fffffff", vif.tdata); end
   endtask

   task automatic test_frames();
      int x, y, f, beats, t0, t1;
      logic ev;
      vif.tready = 1'b1;
      do_reset();
      beats = 0; t0 = -1; t1 = -1;
      for (int c = 0; c < 2 * FRAME; c++) begin
         @(negedge clk);
         f = c / FRAME; x = (c % FRAME) % XT; y = (c % FRAME) / XT;
         ev = (x < XA) && (y < YA);
         checks++; if (vif.tvalid !== ev) begin errors++; $display("FAIL raster_tvalid c=%0d: got %b want %b", c, vif.tvalid, ev); end
         if (ev) begin
            checks++; if (vif.tdata !== exp_pix(x, f)) begin errors++; $display("FAIL raster_tdata c=%0d: got %h want %h", c, vif.tdata, exp_pix(x, f)); end
            checks++; if (vif.tuser !== (x == 0 && y == 0)) begin errors++; $display("FAIL raster_tuser c=%0d: got %b want %b", c, vif.tuser, (x == 0 && y == 0)); end
            checks++; if (vif.tlast !== (x == XA - 1)) begin errors++; $display("FAIL raster_tlast c=%0d: got %b want %b", c, vif.tlast, (x == XA - 1)); end
         end else begin
            checks++; if (vif.tdata !== 32'h0 || vif.tuser !== 1'b0 || vif.tlast !== 1'b0) begin errors++; $display("FAIL blank_outputs c=%0d: got %h/%b/%b want 0/0/0", c, vif.tdata, vif.tuser, vif.tlast); end
         end
         if (c == 0) begin checks++; if (vif.tdata !== 32'h3FFF_FFFF) begin errors++; $display("FAIL white_x0: got %h want 3fffffff", vif.tdata); end end
         if (c == 2) begin checks++; if (vif.tdata !== 32'h3FFF_FC00) begin errors++; $display("FAIL yellow_x2: got %h want 3ffffc00", vif.tdata); end end
         if (c == 14) begin checks++; if (vif.tdata !== 32'h0) begin errors++; $display("FAIL black_x14: got %h want 0", vif.tdata); end end
         if (c < FRAME && vif.tvalid === 1'b1) beats++;
         if (vif.tvalid === 1'b1 && vif.tuser === 1'b1) begin
            if (t0 < 0) t0 = c; else if (t1 < 0) t1 = c;
         end
      end
      checks++; if (beats != BEATS) begin errors++; $display("FAIL beats_per_frame: got %0d want %0d", beats, BEATS); end
      checks++; if (t0 != 0) begin errors++; $display("FAIL first_sof_cycle: got %0d want 0", t0); end
      checks++; if (t1 - t0 != FRAME) begin errors++; $display("FAIL sof_period: got %0d want %0d", t1 - t0, FRAME); end
   endtask

   task automatic test_backpressure();
      logic [31:0] pd;
      logic pu, pl, pstall;
      int k, cyc, f, ln, x;
      do_reset();
      vif.tready = 1'($urandom_range(0, 1));
      k = 0; cyc = 0; pstall = 1'b0; pd = '0; pu = 1'b0; pl = 1'b0;
      while (k < 2 * BEATS && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (pstall) begin
            checks++;
            if (vif.tvalid !== 1'b1 || vif.tdata !== pd || vif.tuser !== pu || vif.tlast !== pl) begin
               errors++; $display("FAIL stall_stable cyc=%0d: got %b/%h/%b/%b want 1/%h/%b/%b", cyc, vif.tvalid, vif.tdata, vif.tuser, vif.tlast, pd, pu, pl);
            end
         end
         if (vif.tvalid === 1'b1 && vif.tready === 1'b1) begin
            f = k / BEATS; ln = (k % BEATS) / XA; x = k % XA;
            checks++; if (vif.tdata !== exp_pix(x, f)) begin errors++; $display("FAIL bp_tdata k=%0d: got %h want %h", k, vif.tdata, exp_pix(x, f)); end
            checks++; if (vif.tuser !== (x == 0 && ln == 0)) begin errors++; $display("FAIL bp_tuser k=%0d: got %b want %b", k, vif.tuser, (x == 0 && ln == 0)); end
            checks++; if (vif.tlast !== (x == XA - 1)) begin errors++; $display("FAIL bp_tlast k=%0d: got %b want %b", k, vif.tlast, (x == XA - 1)); end
            k++;
         end
         pstall = (vif.tvalid === 1'b1) && (vif.tready === 1'b0);
         pd = vif.tdata; pu = vif.tuser; pl = vif.tlast;
         @(posedge clk); #1 vif.tready = 1'($urandom_range(0, 1));
      end
      checks++; if (k != 2 * BEATS) begin errors++; $display("FAIL bp_beat_count: got %0d want %0d", k, 2 * BEATS); end
      vif.tready = 1'b1;
   endtask

   task automatic test_midline_reset();
      vif.tready = 1'b1;
      do_reset();
      repeat (2 * XT + 7) @(posedge clk);
      @(negedge clk);
      checks++; if (vif.tvalid !== 1'b1 || vif.tdata !== 32'h000F_FC00) begin errors++; $display("FAIL pre_reset_y2x7: got %b/%h want 1/000ffc00", vif.tvalid, vif.tdata); end
      rst = 1'b1;
      #1;
      checks++; if (vif.tvalid !== 1'b0 || vif.tdata !== 32'h0) begin errors++; $display("FAIL async_reset_drop: got %b/%h want 0/0", vif.tvalid, vif.tdata); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (vif.tvalid !== 1'b1 || vif.tuser !== 1'b1) begin errors++; $display("FAIL restart_sof: got %b/%b want 1/1", vif.tvalid, vif.tuser); end
      checks++; if (vif.tdata !== 32'h3FFF_FFFF) begin errors++; $display("FAIL restart_white: got %h want 3fffffff", vif.tdata); end
   endtask

`ifdef PATTERN_GEN_MOVING_BARS_EN
   task automatic test_moving_bars();
      vif.tready = 1'b1;
      do_reset();
      repeat (FRAME + 1) @(posedge clk);
      @(negedge clk);
      checks++; if (vif.tdata !== 32'h3FFF_FC00) begin errors++; $display("FAIL move_f1_x1: got %h want 3ffffc00", vif.tdata); end
      repeat (13) @(posedge clk);
      @(negedge clk);
      checks++; if (vif.tdata !== 32'h0) begin errors++; $display("FAIL move_f1_x14: got %h want 0", vif.tdata); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (vif.tdata !== 32'h3FFF_FFFF || vif.tlast !== 1'b1) begin errors++; $display("FAIL move_f1_x15: got %h/%b want 3fffffff/1", vif.tdata, vif.tlast); end
   endtask
`endif

   initial begin
      vif.tready = 1'b1;
      test_reset();
      test_frames();
      test_backpressure();
      test_midline_reset();
`ifdef PATTERN_GEN_MOVING_BARS_EN
      test_moving_bars();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
